cpu_step_controller: RTL and testbench

Run/halt/single-step sequencer for the single-cycle RISC-V datapath on the FPGA board.
- Produces a clock enable `cpu_en`. Each enabled cycle retires exactly one instruction.
- Driven by a run switch and a raw step pushbutton.
- Optionally halts on a PC breakpoint.
- Sits between the board I/O and data_path, alongside the LED/seven-segment debug display, so instructions can be walked one at a time.

---
 rtl/cpu_dbg_pkg.sv | 14 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/cpu_step_controller.sv | 132 +++++++++++++
 tb/tb_cpu_step_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-controller definitions: sequencer state encoding and the datapath word width.
package cpu_dbg_pkg;

    localparam int XLEN    = 32;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } cpu_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchroniser, stability counter and rising-edge pulse.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = '0;
        level_d = level_q;
        // The level only moves after DEBOUNCE_CYCLES back-to-back disagreeing samples.
        if (synced != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Run/halt/single-step clock-enable sequencer for the single-cycle datapath.
// Define CPU_STEP_BREAKPOINT_EN to enable the PC breakpoint and the BRK state.
module cpu_step_controller
    import cpu_dbg_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STEP_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_req,
    input  logic               step_btn,
    input  logic [STEP_W-1:0]  step_count,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    bp_addr,
    input  logic               bp_valid,
    output logic               cpu_en,
    output logic               halted,
    output logic [STATE_W-1:0] state,
    output logic [XLEN-1:0]    retired
);

    logic [1:0]        run_sync_q;
    logic              run_s;
    logic              step_level, step_rise, step_pulse;
    logic              hit;
    logic              en;
    cpu_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_left_q, step_left_d, step_load;
    logic              skip_bp_q, skip_bp_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   retired_q, retired_d;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk       (clk),
        .rst       (rst),
        .raw       (step_btn),
        .level     (step_level),
        .rise_pulse(step_rise)
    );

    assign step_pulse = step_rise & step_level;
    assign run_s      = run_sync_q[1];
    assign step_load  = (step_count == '0) ? STEP_W'(1) : step_count;

`ifdef CPU_STEP_BREAKPOINT_EN
    assign hit = ((state_q == RUN) || (state_q == STEP)) && bp_valid &&
                 (pc == bp_addr) && !skip_bp_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_valid, bp_addr, pc, skip_bp_q};
    assign hit       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        skip_bp_d   = skip_bp_q;
        en          = 1'b0;
        unique case (state_q)
            HALT: begin
                if (run_s) begin
                    state_d = RUN;
                end else if (step_pulse) begin
                    step_left_d = step_load;
                    state_d     = STEP;
                end
            end
            RUN: begin
                if (hit) begin
                    state_d     = BRK;
                    step_left_d = '0;
                end else if (!run_s) begin
                    state_d = HALT;
                end else begin
                    en = 1'b1;
                end
            end
            STEP: begin
                if (hit) begin
                    state_d     = BRK;
                    step_left_d = '0;
                end else begin
                    en          = 1'b1;
                    step_left_d = step_left_q - 1'b1;
                    if (step_left_q == STEP_W'(1)) state_d = HALT;
                end
            end
            BRK: begin
                // Stepping out of BRK must execute the instruction that tripped the breakpoint.
                if (!run_s) begin
                    state_d = HALT;
                end else if (step_pulse) begin
                    step_left_d = step_load;
                    skip_bp_d   = 1'b1;
                    state_d     = STEP;
                end
            end
        endcase
        if (en) skip_bp_d = 1'b0;
        halted_d  = (state_d == HALT) || (state_d == BRK);
        retired_d = retired_q + XLEN'(en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync_q  <= '0;
            state_q     <= HALT;
            step_left_q <= '0;
            skip_bp_q   <= 1'b0;
            halted_q    <= 1'b1;
            retired_q   <= '0;
        end else begin
            run_sync_q  <= {run_sync_q[0], run_req};
            state_q     <= state_d;
            step_left_q <= step_left_d;
            skip_bp_q   <= skip_bp_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign cpu_en  = en;
    assign halted  = halted_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with a cycle-level behavioural model and scoreboard checks.
module tb_cpu_step_controller;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int SW = 8;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_BRK  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run_req = 1'b0;
    logic          step_btn = 1'b0;
    logic [SW-1:0] step_count = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   bp_addr = '0;
    logic          bp_valid = 1'b0;
    logic          cpu_en, halted;
    logic [1:0]    state;
    logic [31:0]   retired;

    always #5 clk = ~clk;

    cpu_step_controller #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .STEP_W         (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_req   (run_req),
        .step_btn  (step_btn),
        .step_count(step_count),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .state     (state),
        .retired   (retired)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;
    int          m_left;
    bit          m_skip;
    logic [31:0] m_retired;
    bit          m_level, m_pulse, m_run_s, last_en;
    bit          btn_hist[8];
    bit          run_hist[8];
    bit          win[$];
    bit          pc_follow = 1'b0;

    function automatic bit model_hit();
`ifdef CPU_STEP_BREAKPOINT_EN
        return ((m_state == M_RUN) || (m_state == M_STEP)) && bp_valid &&
               (pc == bp_addr) && !m_skip;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_en();
        if (model_hit()) return 1'b0;
        if (m_state == M_RUN) return m_run_s;
        return (m_state == M_STEP);
    endfunction

    task automatic model_reset();
        m_state = M_HALT; m_left = 0; m_skip = 0; m_retired = '0;
        m_level = 0; m_pulse = 0; m_run_s = 0; last_en = 0;
        for (int i = 0; i < 8; i++) begin
            btn_hist[i] = 0;
            run_hist[i] = 0;
        end
        win.delete();
    endtask

    task automatic model_step();
        bit en, hit, synced, old_level, all_diff;
        en  = model_en();
        hit = model_hit();
        case (m_state)
            M_HALT: if (m_run_s) m_state = M_RUN;
                    else if (m_pulse) begin
                        m_left  = (step_count == 0) ? 1 : int'(step_count);
                        m_state = M_STEP;
                    end
            M_RUN:  if (hit) begin m_state = M_BRK; m_left = 0; end
                    else if (!m_run_s) m_state = M_HALT;
            M_STEP: if (hit) begin m_state = M_BRK; m_left = 0; end
                    else begin
                        m_left--;
                        if (m_left == 0) m_state = M_HALT;
                    end
            default: if (!m_run_s) m_state = M_HALT;
                     else if (m_pulse) begin
                         m_left  = (step_count == 0) ? 1 : int'(step_count);
                         m_skip  = 1;
                         m_state = M_STEP;
                     end
        endcase
        if (en) m_skip = 0;
        m_retired = m_retired + 32'(en);
        last_en   = en;
        for (int i = 7; i > 0; i--) begin
            btn_hist[i] = btn_hist[i-1];
            run_hist[i] = run_hist[i-1];
        end
        btn_hist[0] = step_btn;
        run_hist[0] = run_req;
        m_run_s   = run_hist[1];
        synced    = btn_hist[S];
        old_level = m_level;
        win.push_back(synced);
        if (win.size() > D) void'(win.pop_front());
        all_diff = (win.size() == D);
        foreach (win[i]) if (win[i] == m_level) all_diff = 0;
        if (all_diff) begin
            m_level = !m_level;
            win.delete();
        end
        m_pulse = m_level && !old_level;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        else last_en = 0;
        #1;
        if (pc_follow && last_en) pc = pc + 32'd4;
    endtask

    // ---------------- per-cycle compare ----------------
    int cur_run = 0;
    int max_run = 0;

    always @(negedge clk) begin
        check("cpu_en", {31'd0, cpu_en}, {31'd0, model_en()});
        check("halted", {31'd0, halted}, ((m_state == M_HALT) || (m_state == M_BRK)) ? 32'd1 : 32'd0);
        check("state", {30'd0, state}, 32'(m_state));
        check("retired", retired, m_retired);
        if (cpu_en) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        model_reset();
        repeat (3) tick();
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd1);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_retired", retired, 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // 1: step_count 0 acts as a single step
        max_run = 0; step_count = 8'd0; step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (12) tick();
        check("t1_retired", retired, 32'd1);
        check("t1_run_len", 32'(max_run), 32'd1);
        check("t1_state", {30'd0, state}, 32'd0);
        check("t1_halted", {31'd0, halted}, 32'd1);

        // 2: five-instruction step
        max_run = 0; step_count = 8'd5; step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (12) tick();
        check("t2_retired", retired, 32'd6);
        check("t2_run_len", 32'(max_run), 32'd5);
        check("t2_state", {30'd0, state}, 32'd0);

        // 3: bounce shorter than the debounce window
        for (int i = 0; i < 15; i++) begin
            step_btn = (i % 2 == 0);
            repeat (2) tick();
        end
        step_btn = 1'b0;
        repeat (12) tick();
        check("t3_retired", retired, 32'd6);

        // 4: free run for 10 request cycles, step press ignored
        max_run = 0; run_req = 1'b1; step_btn = 1'b1;
        repeat (10) tick();
        run_req = 1'b0; step_btn = 1'b0;
        repeat (12) tick();
        check("t4_retired", retired, 32'd15);
        check("t4_run_len", 32'(max_run), 32'd9);
        check("t4_state", {30'd0, state}, 32'd0);

        // 5: breakpoint at 0xC, then step over it
        pc = 32'd0; bp_addr = 32'h0000_000C; bp_valid = 1'b1;
        step_count = 8'd1; pc_follow = 1'b1; run_req = 1'b1;
`ifdef CPU_STEP_BREAKPOINT_EN
        for (int i = 0; i < 40 && m_state != M_BRK; i++) tick();
        check("t5_brk_state", {30'd0, state}, 32'd3);
        check("t5_brk_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("t5_brk_retired", retired, 32'd18);
        step_btn = 1'b1;
        repeat (5) tick();
        run_req = 1'b0;
        repeat (15) tick();
        step_btn = 1'b0;
        repeat (12) tick();
        check("t5_step_retired", retired, 32'd19);
        check("t5_step_state", {30'd0, state}, 32'd0);
        check("t5_step_halted", {31'd0, halted}, 32'd1);
`else
        repeat (20) tick();
        run_req = 1'b0;
        repeat (12) tick();
        check("t5_nobp_retired", retired, 32'd34);
        check("t5_nobp_state", {30'd0, state}, 32'd0);
`endif
        pc_follow = 1'b0; bp_valid = 1'b0;

        // 6: reset in the middle of a long step
        step_count = 8'd100; step_btn = 1'b1;
        repeat (9) tick();
        step_btn = 1'b0;
        begin
            logic [31:0] target;
`ifdef CPU_STEP_BREAKPOINT_EN
            target = 32'd29;
`else
            target = 32'd44;
`endif
            for (int i = 0; i < 60 && m_retired != target; i++) tick();
            check("t6_pre_reset_retired", retired, target);
        end
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("t6_rst_retired", retired, 32'd0);
        check("t6_rst_state", {30'd0, state}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (30) tick();
        check("t6_after_retired", retired, 32'd0);
        check("t6_after_state", {30'd0, state}, 32'd0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
